pam4_upsampler: RTL and testbench
=================================

Name: pam4_upsampler

Overview:
- Transmit-side stage directly upstream of the 33-tap RRC pulse-shaping filter.
- Accepts 2-bit symbols over a valid/ready handshake and Gray-maps them to 4-PAM amplitudes.
- Zero-stuffs each symbol to OSR samples per symbol and drives the filter's 16-bit signed sample input every clock.
- On disable, emits a zero flush so the filter delay line drains cleanly.

Parameters:
- OSR, 4: samples per symbol, must be >= 2; the filter span is 8 symbols at OSR 4.
- AMP, 2048: unit amplitude A; levels are +/-A and +/-3A; 3*AMP must be <= 32767.
- FLUSH_LEN, 33: zero samples emitted after disable; equals the filter tap count.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  run request
- sym_in  in  2  symbol bits
- sym_valid  in  1  sym_in is valid
- sym_ready  out  1  block accepts sym_in this cycle
- dout  out  16 signed  sample to filter din
- sym_strobe  out  1  dout carries a symbol (non-stuffed) sample
- underrun  out  1  sticky: a symbol slot found no symbol
- clear_underrun  in  1  clears underrun
- busy  out  1  state is RUN or FLUSH

Behaviour:
- Reset is async and active-high, per the decided interface. On reset:
  - dout=0, sym_strobe=0, underrun=0, busy=0, sym_ready=1.
  - State IDLE, phase=0, flush count=0, hold register empty.
- Symbol input:
  - One-entry hold register (hold_sym, hold_vld).
  - Accept when sym_valid && sym_ready.
  - sym_ready = !hold_vld || take. take is high only in RUN with phase==0.
  - An accept and a take in the same cycle leave hold_vld=1 with the new symbol.
- Mapping (Gray): 00 -> -3A, 01 -> -A, 11 -> +A, 10 -> +3A. Output is a 16-bit signed constant, so no overflow is possible.
- State machine:
  - IDLE:
    - dout=0, phase held at 0.
    - Go to RUN when enable && hold_vld, so the first slot never underruns.
  - RUN:
    - phase increments every cycle and wraps OSR-1 -> 0.
    - At phase==0: take=1, dout <= map(hold_sym), sym_strobe <= 1.
    - If hold_vld=0 at phase==0: dout <= 0, sym_strobe <= 1, underrun <= 1.
    - Phases 1..OSR-1: dout <= 0, sym_strobe <= 0.
    - If enable is low on a cycle with phase==OSR-1, go to FLUSH. The current symbol period always completes.
  - FLUSH:
    - dout=0 for exactly FLUSH_LEN cycles, then IDLE.
    - enable is ignored until IDLE is reached.
    - sym_ready = !hold_vld, so the next burst can be preloaded.
- Latency:
  - A symbol held in IDLE with enable=1 at edge t gives RUN/phase 0 at t+1.
  - Its mapped value appears on dout at t+2.
  - Steady state: one symbol every OSR cycles.
- dout and sym_strobe are registered (flop outputs); busy is decoded from state.
- underrun:
  - Stays set until clear_underrun.
  - If a set and a clear occur in the same cycle, set wins.
- Reset mid-operation: all outputs return to reset values immediately, without waiting for a clock edge. A held symbol is discarded.

Decomposition:
- Package rrc_tx_pkg holds:
  - sym_t (logic [1:0]) and sample_t (logic signed [15:0]).
  - The state enum {IDLE, RUN, FLUSH}.
  - A pam4_map(sym_t, amp) function returning sample_t.
- No sub-module. Hold register, phase counter, flush counter and FSM stay in one module.

Test Plan:
- Back-to-back mapping:
  - Stimulus: OSR=4, AMP=2048, enable=1, symbols 10,00,01,11 pushed back-to-back.
  - Response: dout = 6144,0,0,0, -6144,0,0,0, -2048,0,0,0, 2048,0,0,0. sym_strobe is high on each nonzero-slot cycle. underrun stays 0.
- Underrun:
  - Stimulus: push a single symbol 11, sym_valid then held low, enable held high.
  - Response: first slot = 2048; next phase-0 slot = 0 with underrun=1. underrun stays 1 until clear_underrun is pulsed, then reads 0.
- Disable mid-period:
  - Stimulus: drop enable at phase 1.
  - Response: phases 2 and 3 give zeros, then exactly 33 zero cycles of FLUSH. busy falls on the cycle after the 33rd. A symbol offered during FLUSH is accepted but not output until enable is set again.
- Backpressure:
  - Stimulus: sym_valid held at 1 for 40 cycles in RUN.
  - Response: exactly one accept per 4 cycles. No symbol is lost or duplicated; the dout slot sequence matches the push order.
- Async reset:
  - Stimulus: assert rst at phase 2 of a 10 symbol, between clock edges.
  - Response: dout=0, busy=0, underrun=0 and sym_ready=1 before the next clock edge. After reset release with enable=1, the block stays in IDLE until a new symbol is accepted.
- Integration impulse:
  - Stimulus: single symbol 10 (6144) into the RRC filter.
  - Response: filter dout shows 6144*tap>>>8 per tap, e.g. tap 0x04ea -> 30192 and tap 0xfff1 -> -360.

Source files
------------

// File: rtl/rrc_tx_pkg.sv
// rtl/rrc_tx_pkg.sv - shared types and the Gray-coded 4-PAM mapper for the RRC transmit path
//
// Purpose: common symbol/sample types, the upsampler state encoding and the
// symbol-to-amplitude mapping used by the stage feeding the RRC filter.
// Ports: none (package).
package rrc_tx_pkg;

  typedef logic [1:0]         sym_t;
  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Gray mapping: adjacent amplitude levels differ in one bit, so a
  // single-level slicer error costs one bit at the receiver.
  //   00 -> -3A, 01 -> -A, 11 -> +A, 10 -> +3A
  function automatic sample_t pam4_map(input sym_t sym, input int amp);
    int level;
    case (sym)
      2'b00:   level = -3 * amp;
      2'b01:   level = -amp;
      2'b11:   level = amp;
      default: level = 3 * amp;
    endcase
    return sample_t'(level);
  endfunction

endpackage

// File: rtl/pam4_upsampler.sv
// rtl/pam4_upsampler.sv - 4-PAM mapper and zero-stuffing upsampler ahead of the RRC filter
//
// Purpose: accepts 2-bit symbols over valid/ready, Gray-maps them to 4-PAM
// amplitudes and emits one mapped sample followed by OSR-1 zeros per symbol.
// After enable drops, the current symbol period completes and FLUSH_LEN zero
// samples are emitted so the downstream filter delay line drains.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enable          run request (sampled at the last phase of each period)
//   sym_in/sym_valid/sym_ready   symbol input handshake
//   dout            registered 16-bit signed sample to the filter
//   sym_strobe      registered, high when dout is a symbol slot
//   underrun        sticky flag, a symbol slot found the hold register empty
//   clear_underrun  clears underrun (a simultaneous set wins)
//   busy            state is RUN or FLUSH
module pam4_upsampler
  import rrc_tx_pkg::*;
#(
  parameter int OSR       = 4,
  parameter int AMP       = 2048,
  parameter int FLUSH_LEN = 33
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         sym_in,
  input  logic               sym_valid,
  output logic               sym_ready,
  output logic signed [15:0] dout,
  output logic               sym_strobe,
  output logic               underrun,
  input  logic               clear_underrun,
  output logic               busy
);

  localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(OSR - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [FW-1:0] flush_q, flush_d;
  sym_t          hold_sym_q;
  logic          hold_vld_q;

  sample_t       dout_d;
  logic          strobe_d;
  logic          underrun_set;
  logic          take;
  logic          accept;

  // A take frees the hold register in the same cycle, so a new symbol can
  // be accepted on the slot cycle and the stream runs without bubbles.
  assign sym_ready = !hold_vld_q || take;
  assign accept    = sym_valid && sym_ready;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    flush_d      = flush_q;
    dout_d       = '0;
    strobe_d     = 1'b0;
    underrun_set = 1'b0;
    take         = 1'b0;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        flush_d = '0;
        // Only start with a symbol already held so the first slot is real.
        if (enable && hold_vld_q) begin
          state_d = RUN;
        end
      end

      RUN: begin
        phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
        if (phase_q == '0) begin
          take     = 1'b1;
          strobe_d = 1'b1;
          if (hold_vld_q) begin
            dout_d = pam4_map(hold_sym_q, AMP);
          end else begin
            underrun_set = 1'b1;
          end
        end
        // Enable is only honoured at the period boundary so a symbol is
        // never truncated.
        if ((phase_q == PHASE_LAST) && !enable) begin
          state_d = FLUSH;
          flush_d = '0;
        end
      end

      FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          state_d = IDLE;
          flush_d = '0;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      flush_q <= flush_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      dout       <= dout_d;
      sym_strobe <= strobe_d;
      if (underrun_set) begin
        underrun <= 1'b1;
      end else if (clear_underrun) begin
        underrun <= 1'b0;
      end
    end
  end

  // Accept has priority over take: a same-cycle accept and take leaves the
  // register full with the new symbol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_sym_q <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      if (accept) begin
        hold_sym_q <= sym_in;
        hold_vld_q <= 1'b1;
      end else if (take) begin
        hold_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pam4_upsampler.sv
// tb/tb_pam4_upsampler.sv - scoreboard bench for pam4_upsampler
module tb_pam4_upsampler;

  localparam int OSR       = 4;
  localparam int AMP       = 2048;
  localparam int FLUSH_LEN = 33;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [1:0]         sym_in;
  logic               sym_valid;
  logic               sym_ready;
  logic signed [15:0] dout;
  logic               sym_strobe;
  logic               underrun;
  logic               clear_underrun;
  logic               busy;

  pam4_upsampler #(.OSR(OSR), .AMP(AMP), .FLUSH_LEN(FLUSH_LEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .sym_in         (sym_in),
    .sym_valid      (sym_valid),
    .sym_ready      (sym_ready),
    .dout           (dout),
    .sym_strobe     (sym_strobe),
    .underrun       (underrun),
    .clear_underrun (clear_underrun),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc_cyc;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   strobe_cnt = 0;
  int   last_strobe = 0;
  bit   run_flag  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_map(input logic [1:0] s);
    case (s)
      2'b00:   return -3 * AMP;
      2'b01:   return -AMP;
      2'b11:   return AMP;
      default: return 3 * AMP;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a slot pops the oldest symbol accepted on an earlier edge;
  // with nothing eligible the slot must be a zero underrun slot.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst) begin
      run_flag = 1'b0;
    end else begin
      if (sym_strobe) begin
        strobe_cnt++;
        if (exp_q.size() > 0 && exp_q[0].acc_cyc < cyc) begin
          e = exp_q.pop_front();
          check("slot_value", longint'(dout), longint'(e.val));
        end else begin
          check("underrun_slot_dout", longint'(dout), 0);
          check("underrun_flag", longint'(underrun), 1);
        end
        if (run_flag) check("strobe_spacing", longint'(cyc - last_strobe), OSR);
        last_strobe = cyc;
        run_flag    = 1'b1;
      end else begin
        check("stuffed_zero", longint'(dout), 0);
      end
      if (!busy) run_flag = 1'b0;
      if (sym_valid && sym_ready) begin
        e.acc_cyc = cyc + 1;
        e.val     = ref_map(sym_in);
        exp_q.push_back(e);
      end
    end
  end

  task automatic send(input logic [1:0] s);
    bit ok = 1'b0;
    sym_in    = s;
    sym_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sym_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    sym_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic wait_strobe();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sym_strobe) begin ok = 1'b1; break; end
    end
    if (!ok) check("strobe_timeout", 0, 1);
  endtask

  task automatic wait_underrun();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (underrun) begin ok = 1'b1; break; end
    end
    if (!ok) check("underrun_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  task automatic drain_and_stop();
    sym_valid = 1'b0;
    wait_drain();
    @(posedge clk);
    #1;
    enable = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n0;
    int cnt;
    int acc_cnt;
    bit acc;
    int gap;

    rst = 1'b1; enable = 1'b0; sym_valid = 1'b0; sym_in = 2'b00; clear_underrun = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_dout", longint'(dout), 0);
    check("reset_strobe", longint'(sym_strobe), 0);
    check("reset_underrun", longint'(underrun), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_sym_ready", longint'(sym_ready), 1);

    // Back-to-back mapping of all four symbols.
    @(posedge clk); #1;
    enable = 1'b1;
    n0 = strobe_cnt;
    send(2'b10); send(2'b00); send(2'b01); send(2'b11);
    drain_and_stop();
    check("b2b_strobes", longint'(strobe_cnt - n0), 4);
    check("b2b_no_underrun", longint'(underrun), 0);

    // Underrun, stickiness, clear.
    enable = 1'b1;
    send(2'b11);
    wait_underrun();
    @(posedge clk); #1;
    check("underrun_sticky", longint'(underrun), 1);
    clear_underrun = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    clear_underrun = 1'b0;
    @(negedge clk);
    check("underrun_cleared", longint'(underrun), 0);
    wait_idle();
    check("underrun_stays_clear", longint'(underrun), 0);

    // Disable mid-period, flush length, preload during FLUSH.
    @(posedge clk); #1;
    enable = 1'b1;
    send(2'b10);
    wait_strobe();
    cnt = 1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (k == 0) enable = 1'b0;
      if (k == 8) begin sym_in = 2'b01; sym_valid = 1'b1; end
      if (k == 9) sym_valid = 1'b0;
      @(negedge clk);
      if (k == 8) check("flush_sym_ready", longint'(sym_ready), 1);
      if (busy) cnt++;
      else break;
    end
    check("flush_busy_cycles", longint'(cnt), (OSR - 1) + FLUSH_LEN);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("idle_with_enable_low", longint'(cnt), 0);
    @(posedge clk); #1;
    enable = 1'b1;
    wait_strobe();
    drain_and_stop();

    // Backpressure: valid held high, exactly one accept per period.
    @(posedge clk); #1;
    enable    = 1'b1;
    sym_in    = 2'($urandom_range(0, 3));
    sym_valid = 1'b1;
    wait_strobe();
    acc_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      acc = sym_valid && sym_ready;
      if (acc) acc_cnt++;
      @(posedge clk); #1;
      if (acc) sym_in = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    check("backpressure_accepts", longint'(acc_cnt), 40 / OSR);
    drain_and_stop();

    // Asynchronous reset at phase 2 of a 10 symbol.
    @(posedge clk); #1;
    enable = 1'b1;
    send(2'b11);
    wait_underrun();
    send(2'b10);
    send(2'b00);
    @(posedge clk); #1;
    check("pre_reset_underrun", longint'(underrun), 1);
    check("pre_reset_ready", longint'(sym_ready), 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_dout", longint'(dout), 0);
    check("async_strobe", longint'(sym_strobe), 0);
    check("async_busy", longint'(busy), 0);
    check("async_underrun", longint'(underrun), 0);
    check("async_sym_ready", longint'(sym_ready), 1);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy || sym_strobe) cnt++;
    end
    check("post_reset_idle", longint'(cnt), 0);
    send(2'b01);
    drain_and_stop();

    // Randomized traffic with enable toggling.
    for (int n = 0; n < 80; n++) begin
      enable = ($urandom_range(0, 4) != 0);
      if (enable) send(2'($urandom_range(0, 3)));
      gap = $urandom_range(0, 5);
      repeat (gap) begin @(posedge clk); #1; end
    end
    enable = 1'b1;
    drain_and_stop();
    check("final_queue_empty", longint'(exp_q.size()), 0);
    check("final_busy", longint'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
